// File: rtl/axil_reg_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
// Response codes, word-index classification and byte-strobe merge.
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        KIND_RW,
        KIND_RO,
        KIND_BAD
    } idx_kind_t;

    // RW words come first, RO words follow, anything beyond is unmapped.
    function automatic idx_kind_t classify_idx(
        input int unsigned idx,
        input int unsigned num_rw,
        input int unsigned num_ro
    );
        if (idx < num_rw) begin
            return KIND_RW;
        end
        if (idx < num_rw + num_ro) begin
            return KIND_RO;
        end
        return KIND_BAD;
    endfunction

    function automatic logic [31:0] merge_strb(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_reg_bank_wr_capture.sv
// AXI4-Lite write-side capture: AW/W holding registers and B response.
// Emits a single-cycle commit strobe toward the register array.
module axil_wr_capture
    import axil_reg_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NUM_RW = 8,
    parameter int NUM_RO = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit_rw,
    output logic [ADDR_W-3:0] commit_idx,
    output logic [31:0]       commit_data,
    output logic [3:0]        commit_strb
);

    logic              live;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-3:0] aw_idx;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              commit;
    idx_kind_t         aw_kind;
    logic              unused_lsb;

    assign unused_lsb = ^awaddr[1:0];

    // Readies come from flops only; held off until the first edge out of reset.
    assign awready = live && !aw_held;
    assign wready  = live && !w_held;

    // A pending B response blocks the next commit so no response is lost.
    assign commit  = aw_held && w_held && !bvalid;
    assign aw_kind = classify_idx(32'(aw_idx), NUM_RW, NUM_RO);

    assign commit_rw   = commit && (aw_kind == KIND_RW);
    assign commit_idx  = aw_idx;
    assign commit_data = w_data;
    assign commit_strb = w_strb;

    // Track that reset has been released at least one edge ago.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Latch the write address; release it on commit.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_held <= 1'b0;
            aw_idx  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
        end else if (awvalid && awready) begin
            aw_held <= 1'b1;
            aw_idx  <= awaddr[ADDR_W-1:2];
        end
    end

    // Latch write data and strobes; release them on commit.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_held <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (commit) begin
            w_held <= 1'b0;
        end else if (wvalid && wready) begin
            w_held <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
        end
    end

    // Raise B on commit, drop it once the master accepts it.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= (aw_kind == KIND_RW) ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid && bready) begin
            bvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: RW control words, RO status words.
// Write pulses let EMIF writes trigger fabric actions.
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          NUM_RW     = 8,
    parameter int          NUM_RO     = 8,
    parameter logic [31:0] RW_RST_VAL = 32'h0
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_axil_awaddr,
    input  logic [2:0]          s_axil_awprot,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,
    input  logic [31:0]         s_axil_wdata,
    input  logic [3:0]          s_axil_wstrb,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,
    output logic [1:0]          s_axil_bresp,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,
    input  logic [ADDR_W-1:0]   s_axil_araddr,
    input  logic [2:0]          s_axil_arprot,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,
    output logic [31:0]         s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready,
    output logic [32*NUM_RW-1:0] ctrl_regs,
    output logic [NUM_RW-1:0]   ctrl_wr_pulse,
    input  logic [32*NUM_RO-1:0] status_in
);

    localparam int IDX_W = ADDR_W - 2;

    logic [NUM_RW-1:0][31:0] ctrl_q;
    logic [NUM_RW-1:0]       wr_pulse;
    logic                    cm_rw;
    logic [IDX_W-1:0]        cm_idx;
    logic [31:0]             cm_data;
    logic [3:0]              cm_strb;
    logic                    rd_live;
    logic [IDX_W-1:0]        ar_idx;
    idx_kind_t               rd_kind;
    logic [31:0]             rd_word;
    logic [1:0]              rd_resp;
    logic                    unused_in;

    assign unused_in = ^{s_axil_awprot, s_axil_arprot, s_axil_araddr[1:0]};

    axil_wr_capture #(
        .ADDR_W (ADDR_W),
        .NUM_RW (NUM_RW),
        .NUM_RO (NUM_RO)
    ) u_wr (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .awaddr      (s_axil_awaddr),
        .awvalid     (s_axil_awvalid),
        .awready     (s_axil_awready),
        .wdata       (s_axil_wdata),
        .wstrb       (s_axil_wstrb),
        .wvalid      (s_axil_wvalid),
        .wready      (s_axil_wready),
        .bresp       (s_axil_bresp),
        .bvalid      (s_axil_bvalid),
        .bready      (s_axil_bready),
        .commit_rw   (cm_rw),
        .commit_idx  (cm_idx),
        .commit_data (cm_data),
        .commit_strb (cm_strb)
    );

    assign ctrl_regs     = ctrl_q;
    assign ctrl_wr_pulse = wr_pulse;

    // Apply committed writes byte-wise and pulse the written word for one cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_RW; i++) begin
                ctrl_q[i] <= RW_RST_VAL;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (cm_rw && cm_idx == IDX_W'(i)) begin
                    ctrl_q[i]   <= merge_strb(ctrl_q[i], cm_data, cm_strb);
                    wr_pulse[i] <= 1'b1;
                end
            end
        end
    end

    assign ar_idx  = s_axil_araddr[ADDR_W-1:2];
    assign rd_kind = classify_idx(32'(ar_idx), NUM_RW, NUM_RO);

    // Select the word addressed by AR; unmapped words read as zero with SLVERR.
    always_comb begin
        rd_word = '0;
        rd_resp = RESP_SLVERR;
        unique case (rd_kind)
            KIND_RW: begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < NUM_RW; i++) begin
                    if (ar_idx == IDX_W'(i)) begin
                        rd_word = ctrl_q[i];
                    end
                end
            end
            KIND_RO: begin
                rd_resp = RESP_OKAY;
                for (int j = 0; j < NUM_RO; j++) begin
                    if (ar_idx == IDX_W'(NUM_RW + j)) begin
                        rd_word = status_in[32*j +: 32];
                    end
                end
            end
            default: begin
                rd_word = '0;
                rd_resp = RESP_SLVERR;
            end
        endcase
    end

    // One outstanding read; arready is the inverse of the held response.
    assign s_axil_arready = rd_live && !s_axil_rvalid;

    // Capture the read word at the AR handshake and hold it until R is taken.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_live       <= 1'b0;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else begin
            rd_live <= 1'b1;
            if (s_axil_arvalid && s_axil_arready) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_word;
                s_axil_rresp  <= rd_resp;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
AXI4-Lite slave register bank that sits directly downstream of the EMIF-to-AXI-Lite bridge master. It terminates the bridge's AW/W/B/AR/R channels.
- Provides NUM_RW read/write control registers, driven out to fabric logic.
- Provides NUM_RO read-only status registers, sampled from fabric inputs.
- Emits a one-cycle write pulse per control register, so the DSP can trigger fabric actions through EMIF writes.

Parameters:
ADDR_W, 16, AXI-Lite address bits decoded (byte address; bits [1:0] ignored)
NUM_RW, 8, number of read/write registers, word index 0..NUM_RW-1
NUM_RO, 8, number of read-only registers, word index NUM_RW..NUM_RW+NUM_RO-1
RW_RST_VAL, 32'h0, reset value of every RW register

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  reset, synchronous, active-low
s_axil_awaddr  in  ADDR_W  write address
s_axil_awprot  in  3  ignored
s_axil_awvalid  in  1  AW valid
s_axil_awready  out  1  AW ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte strobes
s_axil_wvalid  in  1  W valid
s_axil_wready  out  1  W ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  B valid
s_axil_bready  in  1  B ready
s_axil_araddr  in  ADDR_W  read address
s_axil_arprot  in  3  ignored
s_axil_arvalid  in  1  AR valid
s_axil_arready  out  1  AR ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  R valid
s_axil_rready  in  1  R ready
ctrl_regs  out  32*NUM_RW  RW register contents, reg i at [32i+31:32i]
ctrl_wr_pulse  out  NUM_RW  one-cycle pulse per RW register written
status_in  in  32*NUM_RO  RO register sources, reg j at [32j+31:32j]

Behaviour:
- Reset (aresetn=0 at rising edge):
  - awready/wready/arready=0, bvalid=0, rvalid=0, bresp=rresp=0, rdata=0.
  - All RW registers = RW_RST_VAL; ctrl_wr_pulse=0; holding registers cleared.
  - Reset mid-transaction abandons it; the master is reset by the same aresetn.
- Out of reset:
  - awready = !aw_held.
  - wready = !w_held.
  - arready = !rvalid.
  - All are registered-free combinational functions of internal flops only; no dependency on input valids.
- Write channel:
  - AW and W are accepted independently, in either order or the same cycle. Address and data+strb are latched into aw_held/w_held.
  - Commit edge: first rising edge where aw_held && w_held && !bvalid. At that edge:
    - Target register bytes with wstrb=1 are updated.
    - aw_held and w_held are cleared.
    - bvalid goes to 1 and bresp is set.
    - If the target is RW index i, ctrl_wr_pulse[i]=1 for exactly that next cycle.
  - Minimum latency: AW+W handshake at edge N gives commit and bvalid=1 at edge N+1.
  - bvalid holds until bready. If B is back-pressured, a second AW/W may be latched but does not commit until bvalid clears. No write is lost or duplicated.
  - bresp: 2'b00 (OKAY) for an RW index. 2'b10 (SLVERR) for an RO index or an index >= NUM_RW+NUM_RO; no state change and no pulse in that case.
- Read channel:
  - AR handshake at edge N gives rvalid=1 at edge N+1, with rdata holding the register value sampled at edge N.
  - RO rdata is status_in sampled at edge N.
  - Out of range: rdata=0, rresp=2'b10.
  - rvalid and rdata hold stable until rready; no new AR is accepted while rvalid=1.
- Read/write collision on the same register at the same edge: the read returns the pre-write value.
- Word index = addr[ADDR_W-1:2]. Address bits above the decoded range are not checked; the upstream bridge already masks them.
- Read and write paths are fully independent; they may complete on the same cycle.

Decomposition:
- Package axil_reg_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - A function for index-range classification (RW / RO / invalid) parameterised by NUM_RW and NUM_RO.
- No sub-module is required. An optional axil_wr_capture sub-module (AW/W holding registers plus commit/B logic) is natural if the read path is kept in the top.

Test Plan:
1. Reset, then check all outputs → every ctrl_regs word = 0, all valids=0, awready=wready=arready=1.
2. AW(addr 0x0008) and W(0xDEADBEEF, strb F) in the same cycle, bready=1 → bvalid one cycle later with bresp=00; ctrl_regs word2=0xDEADBEEF; ctrl_wr_pulse=8'b0000_0100 for 1 cycle.
3. W(0x000000AA, strb 4'b0001) three cycles before AW(0x0004) → word1 low byte=0xAA, other bytes unchanged; commit occurs the edge after AW.
4. status_in word0=0x12345678, AR 0x0020 (index 8), rready held low 5 cycles → rvalid stays high, rdata=0x12345678 stable, rresp=00, arready=0 throughout.
5. Write to 0x0020 (RO) and to 0x0100 (index 64) → bresp=10 both times; no ctrl_regs change; no pulse. Read of 0x0100 → rdata=0, rresp=10.
6. bready held low after a write to index 0, then a second AW/W to index 1 → the second write does not commit until the first B completes; exactly two B responses; word0 and word1 both updated.
